// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types and reset constants for the LED bank.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    localparam led_mode_t LED_RST_MODE = LED_BLINK;

endpackage
`default_nettype wire

// File: rtl/led_chan.sv
`default_nettype none
// ============================================================================
// Module      : led_chan
// Description : One LED channel: config registers, free-running counter,
//               clamped blink tap, PWM comparator and registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module led_chan
    import led_pkg::*;
#(
    parameter int DIV_W    = 5,
    parameter int PWM_W    = 8,
    parameter int CNT_W    = 32,
    parameter int TAP_BASE = 22
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             led_o,
    output logic             busy_o
);

    // Tap index width; the sum is formed wider so TAP_BASE + div never wraps
    // before the clamp.
    localparam int c_tap_w = $clog2(CNT_W) + 1;
    localparam int c_sum_w = ((DIV_W > c_tap_w) ? DIV_W : c_tap_w) + 1;
    localparam logic [c_sum_w-1:0] c_tap_base = c_sum_w'(TAP_BASE);
    localparam logic [c_sum_w-1:0] c_tap_max  = c_sum_w'(CNT_W - 1);

    led_mode_t          r_mode_q, w_mode_d;
    logic [DIV_W-1:0]   r_div_q,  w_div_d;
    logic [PWM_W-1:0]   r_duty_q, w_duty_d;
    logic [CNT_W-1:0]   r_cnt_q,  w_cnt_d;
    logic               r_led_q,  w_led_d;
    logic               r_busy_q, w_busy_d;

    logic [c_sum_w-1:0] w_tap_sum;
    logic [c_tap_w-1:0] w_tap;
    logic [CNT_W-1:0]   w_cnt_shift;

    // Blink tap: TAP_BASE + div, clamped to the counter MSB.
    always_comb begin
        w_tap_sum = c_tap_base + c_sum_w'(r_div_q);
        if (w_tap_sum > c_tap_max) begin
            w_tap = c_tap_w'(c_tap_max);
        end else begin
            w_tap = c_tap_w'(w_tap_sum);
        end
        w_cnt_shift = r_cnt_q >> w_tap;
    end

    // Next LED value from the pre-edge channel state.
    always_comb begin
        w_led_d = 1'b0;
        case (r_mode_q)
            LED_OFF:   w_led_d = 1'b0;
            LED_ON:    w_led_d = 1'b1;
            LED_BLINK: w_led_d = w_cnt_shift[0];
            LED_PWM:   w_led_d = (r_cnt_q[PWM_W-1:0] < r_duty_q);
            default:   w_led_d = 1'b0;
        endcase
    end

    // Config load on write; counter free-runs and restarts on every write.
    always_comb begin
        w_mode_d = r_mode_q;
        w_div_d  = r_div_q;
        w_duty_d = r_duty_q;
        w_cnt_d  = r_cnt_q + CNT_W'(1);
        w_busy_d = 1'b0;
        if (wr_i) begin
            w_mode_d = led_mode_t'(mode_i);
            w_div_d  = div_i;
            w_duty_d = duty_i;
            w_cnt_d  = '0;
            w_busy_d = 1'b1;
        end
    end

    // State registers; reset wins over a same-edge write.
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_mode_q <= LED_RST_MODE;
            r_div_q  <= '0;
            r_duty_q <= '0;
            r_cnt_q  <= '0;
            r_led_q  <= 1'b0;
            r_busy_q <= 1'b0;
        end else begin
            r_mode_q <= w_mode_d;
            r_div_q  <= w_div_d;
            r_duty_q <= w_duty_d;
            r_cnt_q  <= w_cnt_d;
            r_led_q  <= w_led_d;
            r_busy_q <= w_busy_d;
        end
    end

    assign led_o  = r_led_q;
    assign busy_o = r_busy_q;

endmodule
`default_nettype wire

// File: rtl/led_bank.sv
`default_nettype none
// ============================================================================
// Module      : led_bank
// Description : Multi-channel LED driver: write-select decode feeding an
//               array of independent led_chan instances.
// Revision    : 1.0 - initial release
// ============================================================================
module led_bank
    import led_pkg::*;
#(
    parameter int NUM_LED  = 2,
    parameter int DIV_W    = 5,
    parameter int PWM_W    = 8,
    parameter int CNT_W    = 32,
    parameter int TAP_BASE = 22,
    parameter int SEL_W    = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic               wren_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic [1:0]         mode_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [PWM_W-1:0]   duty_i,
    output logic [NUM_LED-1:0] led_o,
    output logic [NUM_LED-1:0] busy_o
);

    logic [NUM_LED-1:0] w_wr;

    // One channel per LED; a select value with no matching channel hits none.
    for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
        assign w_wr[i] = wren_i && (sel_i == SEL_W'(i));

        led_chan #(
            .DIV_W    (DIV_W),
            .PWM_W    (PWM_W),
            .CNT_W    (CNT_W),
            .TAP_BASE (TAP_BASE)
        ) u_chan (
            .clk100 (clk100),
            .rst    (rst),
            .wr_i   (w_wr[i]),
            .mode_i (mode_i),
            .div_i  (div_i),
            .duty_i (duty_i),
            .led_o  (led_o[i]),
            .busy_o (busy_o[i])
        );
    end

endmodule
`default_nettype wire
